// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: small circular buffer of (PC, instruction)
// pairs with valid/ready on both sides and a synchronous flush for redirects.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module if_id_queue #(
    parameter int WORD_WIDTH  = `WORD_WIDTH,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WORD_WIDTH-1:0]      in_pc,
    input  logic [INSTR_WIDTH-1:0]     in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WORD_WIDTH-1:0]      out_pc,
    output logic [INSTR_WIDTH-1:0]     out_instr,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WORD_WIDTH-1:0]  pc_mem    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count_q;
    logic             push;
    logic             pop;

    // Handshake qualifiers depend only on registered occupancy.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count_q <= count_q + 1'b1;
            else if (pop && !push)
                count_q <= count_q - 1'b1;
        end
    end

    // Storage is never cleared; a flush or reset only drops the pointers.
    always_ff @(posedge CLK) begin
        if (push && !flush && !RST) begin
            pc_mem[wr_ptr]    <= in_pc;
            instr_mem[wr_ptr] <= in_instr;
        end
    end

    // Empty queue presents a zero PC and a NOP bubble rather than stale data.
    assign out_pc    = out_valid ? pc_mem[rd_ptr]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed self-checking bench for if_id_queue: reset, fill/stall, drain with
// pointer wrap, simultaneous push/pop, flush and reset mid-stream.
module tb_if_id_queue;

    logic        CLK;
    logic        RST;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic [2:0]  count;

    int n_checks;
    int n_fail;

    if_id_queue #(
        .WORD_WIDTH (32),
        .INSTR_WIDTH(32),
        .DEPTH      (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .flush    (flush),
        .in_valid (in_valid),
        .in_pc    (in_pc),
        .in_instr (in_instr),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_pc   (out_pc),
        .out_instr(out_instr),
        .out_ready(out_ready),
        .count    (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return at the falling edge to sample and drive.
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] ins);
        in_valid = v;
        in_pc    = pc;
        in_instr = ins;
    endtask

    initial begin
        int idx;
        int next_pc;
        int cycles;
        logic will_push;

        n_checks  = 0;
        n_fail    = 0;
        RST       = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        offer(1'b1, 32'h55, 32'hDEAD);

        // Reset held for two cycles with an offer present.
        step();
        step();
        check("rst_count", count, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_pc", out_pc, 0);
        check("rst_out_instr", out_instr, 0);
        check("rst_in_ready", in_ready, 1);

        // Fill with decode stalled.
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(1'b1, 32'(i), 32'hA0 + 32'(i));
            step();
            if (i == 0) begin
                check("first_push_visible", out_valid, 1);
                check("first_push_pc", out_pc, 0);
            end
        end
        check("full_count", count, 4);
        check("full_in_ready", in_ready, 0);

        // Fifth offer is refused; head stays put for the whole stall.
        offer(1'b1, 32'd4, 32'hA4);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_count", count, 4);
            check("stall_head_pc", out_pc, 0);
            check("stall_head_instr", out_instr, 32'hA0);
        end

        // At full with both sides active only the pop happens.
        out_ready = 1'b1;
        step();
        check("full_pop_only_count", count, 3);
        check("full_pop_only_head", out_pc, 1);
        check("reassert_in_ready", in_ready, 1);

        // Drain while refilling pc 4..7; output must be 1..7 in order.
        idx     = 1;
        next_pc = 4;
        cycles  = 0;
        while (idx < 8 && cycles < 40) begin
            if (out_valid) begin
                check("drain_pc", out_pc, 32'(idx));
                check("drain_instr", out_instr, 32'hA0 + 32'(idx));
                idx++;
            end
            offer(next_pc < 8, 32'(next_pc), 32'hA0 + 32'(next_pc));
            will_push = in_valid && in_ready;
            step();
            if (will_push)
                next_pc++;
            cycles++;
        end
        check("drain_all_seen", 64'(idx), 8);
        check("drain_empty_count", count, 0);
        check("drain_empty_valid", out_valid, 0);
        check("drain_empty_instr", out_instr, 0);

        // Simultaneous push and pop at count 2.
        out_ready = 1'b0;
        offer(1'b1, 32'h20, 32'hB0);
        step();
        offer(1'b1, 32'h21, 32'hB1);
        step();
        check("pp_pre_count", count, 2);
        out_ready = 1'b1;
        offer(1'b1, 32'h22, 32'hB2);
        step();
        check("pp_count", count, 2);
        check("pp_head_pc", out_pc, 32'h21);
        check("pp_head_instr", out_instr, 32'hB1);
        offer(1'b0, 32'h0, 32'h0);
        step();
        check("pp_next_pc", out_pc, 32'h22);
        check("pp_next_count", count, 1);

        // Build up to count 3, then flush with push and pop requested.
        out_ready = 1'b0;
        offer(1'b1, 32'h23, 32'hB3);
        step();
        offer(1'b1, 32'h24, 32'hB4);
        step();
        check("preflush_count", count, 3);
        flush     = 1'b1;
        out_ready = 1'b1;
        offer(1'b1, 32'd9, 32'hC9);
        step();
        check("flush_count", count, 0);
        check("flush_out_valid", out_valid, 0);
        check("flush_in_ready", in_ready, 1);
        check("flush_out_pc", out_pc, 0);
        flush     = 1'b0;
        out_ready = 1'b0;
        offer(1'b1, 32'd10, 32'hCA);
        step();
        check("postflush_valid", out_valid, 1);
        check("postflush_pc", out_pc, 32'd10);
        check("postflush_instr", out_instr, 32'hCA);
        check("postflush_count", count, 1);

        // Reset mid-stream wins over flush and push.
        offer(1'b1, 32'd11, 32'hCB);
        step();
        check("prerst_count", count, 2);
        RST   = 1'b1;
        flush = 1'b1;
        offer(1'b1, 32'd12, 32'hCC);
        step();
        check("midrst_count", count, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_pc", out_pc, 0);
        check("midrst_out_valid", out_valid, 0);
        RST   = 1'b0;
        flush = 1'b0;
        offer(1'b1, 32'd13, 32'hCD);
        step();
        check("postrst_pc", out_pc, 32'd13);
        check("postrst_instr", out_instr, 32'hCD);
        offer(1'b0, 32'h0, 32'h0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction fetch queue sitting directly downstream of the program counter, between fetch and decode. Each cycle it can accept one (PC, instruction) pair, tagged valid, from the fetch side and buffer it in a small FIFO. It presents the oldest entry to decode through a valid/ready handshake. It also absorbs decode stalls, exposes back-pressure for PC hold logic, and discards all in-flight instructions on a branch/jump flush.

## Interface
- WORD_WIDTH, default `WORD_WIDTH from defines.v: width of PC values.
- INSTR_WIDTH, default 32: width of an instruction word.
- DEPTH, default 4: number of entries; power of two, ≥ 2.
- CLK  input  1  clock; all state updates on its rising edge.
- RST  input  1  synchronous, active-high reset; sampled on the CLK rising edge.
- flush  input  1  synchronous flush; discards all entries.
- in_valid  input  1  fetch side offers an entry this cycle.
- in_pc  input  WORD_WIDTH  PC of the offered instruction.
- in_instr  input  INSTR_WIDTH  offered instruction word.
- in_ready  output  1  queue can accept; equals (count != DEPTH).
- out_valid  output  1  head entry present; equals (count != 0).
- out_pc  output  WORD_WIDTH  PC of the head entry; 0 when empty.
- out_instr  output  INSTR_WIDTH  instruction of the head entry; 0 (NOP bubble) when empty.
- out_ready  input  1  decode consumes the head this cycle.
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH-entry circular buffer with read pointer rd_ptr and write pointer wr_ptr, each clog2(DEPTH) bits, plus an occupancy counter. Pointers wrap modulo DEPTH naturally.
- Push: occurs when in_valid && in_ready. Writes {in_pc, in_instr} at wr_ptr, then wr_ptr+1.
- Pop: occurs when out_valid && out_ready. rd_ptr+1.
- count update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full (count == DEPTH):
  - in_ready = 0, so no push occurs even if a pop happens the same cycle.
  - in_ready depends only on registered count, never combinationally on out_ready.
- Empty (count == 0):
  - out_valid = 0 and out_pc/out_instr = 0.
  - out_ready is ignored.
  - A push into an empty queue does not bypass to the output.
- Offer ignored: in_valid while in_ready = 0 drops nothing internally. Holding the offer (or holding the PC) is the upstream's responsibility.
- Flush:
  - On the next edge, count, rd_ptr and wr_ptr become 0.
  - Any push or pop in the flush cycle is discarded.
  - Stored data is not cleared.
- Priority: RST > flush > push/pop.
- Reset state: count 0, rd_ptr 0, wr_ptr 0. Resulting outputs: in_ready 1, out_valid 0, out_pc 0, out_instr 0. Storage contents are don't-care.
- Outputs are a function of registered state only; there is no combinational input-to-output path.

## Timing
- Latency: an entry pushed at edge N is visible on out_* immediately after edge N. Decode can consume it in the cycle following the push.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Stall: with out_ready = 0, the head entry and out_* remain stable for every cycle the stall lasts.
- in_ready deasserts in the cycle after the push that fills the queue. It reasserts in the cycle after the first pop from full.
- Flush: out_valid = 0 and in_ready = 1 in the cycle after the flush edge. The first post-flush push becomes visible one cycle later.
- Reset mid-operation: behaves identically to flush and also re-initialises all state. No entry survives.

## Test plan
- Reset/empty: assert RST for 2 cycles with in_valid = 1 → count 0, out_valid 0, out_pc 0, out_instr 0, in_ready 1.
- Fill and stall: out_ready = 0, push pc 0..3 with instr 0xA0..0xA3 → count 4 after 4 edges and in_ready 0. A 5th offer (pc 4) is not stored. Head stays pc 0 / 0xA0.
- Drain with wrap: from the previous state, out_ready = 1 while pushing pc 4..7 whenever in_ready → outputs pc 0..7 in order with matching instrs and no duplicates. Pointers wrap past DEPTH−1.
- Simultaneous push/pop at count 2 → count stays 2, order preserved. At count 4 with out_ready = 1 and in_valid = 1 → only the pop occurs, count 3.
- Flush: count 3, assert flush together with in_valid (pc 9) and out_ready → next cycle count 0, out_valid 0. A push of pc 10 the following cycle appears as the head.
- Reset mid-stream: count 2, assert RST together with flush and in_valid → count 0, in_ready 1, out_pc 0.
